// File: rtl/multi_clk_divider_if.sv
// multi_clk_divider_if: control and output bundle for multi_clk_divider
//   en       per-channel count enable
//   wr_en    divisor write strobe; wr_ch selects the channel, wr_div is the new divisor
//   tick     one-cycle strobe at the end of each channel period
//   slow_clk 50 % square wave toggling on every tick
//   sync     (only with MULTI_CLK_DIV_SYNC_EN) phase-aligns every channel
interface multi_clk_divider_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 26
);
  localparam int WR_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] en;
  logic wr_en;
  logic [WR_W-1:0] wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] slow_clk;
`ifdef MULTI_CLK_DIV_SYNC_EN
  logic sync;
`endif
  modport master (
`ifdef MULTI_CLK_DIV_SYNC_EN
    output sync,
`endif
    output en, wr_en, wr_ch, wr_div,
    input tick, slow_clk
  );
  modport slave (
`ifdef MULTI_CLK_DIV_SYNC_EN
    input sync,
`endif
    input en, wr_en, wr_ch, wr_div,
    output tick, slow_clk
  );
endinterface

// File: rtl/multi_clk_divider.sv
// multi_clk_divider: NUM_CH independent runtime-programmable clock dividers
//   clk, rst  system clock, synchronous active-high reset
//   bus       multi_clk_divider_if.slave: en, wr_en/wr_ch/wr_div in; tick, slow_clk out
//   Optional macro MULTI_CLK_DIV_SYNC_EN adds bus.sync to phase-align all channels.
module multi_clk_divider #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 26,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input logic clk,
  input logic rst,
  multi_clk_divider_if.slave bus
);
  logic sync;
`ifdef MULTI_CLK_DIV_SYNC_EN
  assign sync = bus.sync;
`else
  assign sync = 1'b0;
`endif
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] div, cnt;
    logic tick, slow, hit, run, tc;
    // an equality match on the channel index also rejects wr_ch >= NUM_CH
    assign hit = bus.wr_en && int'(bus.wr_ch) == g;
    assign run = bus.en[g] && div != '0;
    // div-1 is only looked at when div is non-zero, so it never wraps
    assign tc = run && cnt == div - CNT_W'(1);
    always_ff @(posedge clk)
      if (rst) begin
        div <= CNT_W'(DEFAULT_DIV);
        cnt <= '0;
        tick <= 1'b0;
        slow <= 1'b0;
      end else if (hit || sync) begin
        div <= hit ? bus.wr_div : div;
        cnt <= '0;
        tick <= 1'b0;
        slow <= sync ? 1'b0 : slow;
      end else begin
        cnt <= tc ? '0 : run ? cnt + CNT_W'(1) : cnt;
        tick <= tc;
        slow <= slow ^ tc;
      end
    assign bus.tick[g] = tick;
    assign bus.slow_clk[g] = slow;
  end
endmodule

// File: tb/tb_multi_clk_divider.sv
// tb_multi_clk_divider: scoreboard bench; expectations are queued per cycle, a monitor checks them
module tb_multi_clk_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  multi_clk_divider_if #(.NUM_CH(2), .CNT_W(8)) b ();
  multi_clk_divider_if #(.NUM_CH(3), .CNT_W(8)) b3 ();
  multi_clk_divider #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(4)) dut (.clk(clk), .rst(rst), .bus(b));
  // three-channel copy so that an out-of-range channel index is representable
  multi_clk_divider #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  typedef struct {
    int cyc;
    int d3;
    int ch;
    logic [1:0] ts;
    string name;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int t0;
  // cyc is the index of the cycle that follows the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;
  // expected {tick, slow_clk} of one channel during cycle c
  task automatic e(input int c, input int d3, input int ch, input logic [1:0] ts, input string name);
    sb.push_back('{c, d3, ch, ts, name});
  endtask
  always @(posedge clk) begin
    #1;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc <= cyc) begin
        logic [1:0] act;
        act = sb[i].d3 != 0 ? {b3.tick[sb[i].ch], b3.slow_clk[sb[i].ch]}
                            : {b.tick[sb[i].ch], b.slow_clk[sb[i].ch]};
        total++;
        if (sb[i].cyc != cyc || act !== sb[i].ts) begin
          bad++;
          $display("FAIL %s cycle %0d dut%0d ch%0d: tick,slow_clk got %b want %b",
                   sb[i].name, sb[i].cyc, sb[i].d3 != 0 ? 3 : 2, sb[i].ch, act, sb[i].ts);
        end
        sb.delete(i);
      end
  end
  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic wr(input int c, input int ch, input int d);
    at(c);
    b.wr_en = 1'b1;
    b.wr_ch = 1'(ch);
    b.wr_div = 8'(d);
    @(negedge clk);
    b.wr_en = 1'b0;
  endtask
  task automatic wr3(input int c, input int ch, input int d);
    at(c);
    b3.wr_en = 1'b1;
    b3.wr_ch = 2'(ch);
    b3.wr_div = 8'(d);
    @(negedge clk);
    b3.wr_en = 1'b0;
  endtask
  // holds rst for two edges, checks the reset outputs, then releases with all channels enabled;
  // t0 is "cycle 0", the first cycle with rst=0 and en=1
  task automatic do_reset(output int t);
    @(negedge clk);
    rst = 1'b1;
    b.en = '0;
    b.wr_en = 1'b0;
    b3.en = '0;
    b3.wr_en = 1'b0;
`ifdef MULTI_CLK_DIV_SYNC_EN
    b.sync = 1'b0;
`endif
    @(negedge clk);
    for (int ch = 0; ch < 2; ch++) e(cyc + 1, 0, ch, 2'b00, "reset");
    for (int ch = 0; ch < 3; ch++) e(cyc + 1, 1, ch, 2'b00, "reset3");
    @(negedge clk);
    rst = 1'b0;
    b.en = '1;
    b3.en = '1;
    t = cyc;
  endtask
  initial begin
    b.en = '0;
    b.wr_en = 1'b0;
    b.wr_ch = '0;
    b.wr_div = '0;
    b3.en = '0;
    b3.wr_en = 1'b0;
    b3.wr_ch = '0;
    b3.wr_div = '0;
`ifdef MULTI_CLK_DIV_SYNC_EN
    b.sync = 1'b0;
`endif
    // default divisor 4 on both channels, then ch1 rewritten to 3 (lands on the edge opening cycle 5)
    do_reset(t0);
    e(t0 + 3, 0, 0, 2'b00, "t1_pre");
    e(t0 + 4, 0, 0, 2'b11, "t1_tick4");
    e(t0 + 5, 0, 0, 2'b01, "t1_after");
    e(t0 + 7, 0, 0, 2'b01, "t1_hold");
    e(t0 + 8, 0, 0, 2'b10, "t1_tick8");
    e(t0 + 11, 0, 0, 2'b00, "t1_low");
    e(t0 + 12, 0, 0, 2'b11, "t1_tick12");
    e(t0 + 4, 0, 1, 2'b11, "t1_ch1");
    e(t0 + 7, 0, 1, 2'b01, "t2_pre");
    e(t0 + 8, 0, 1, 2'b10, "t2_tick8");
    e(t0 + 10, 0, 1, 2'b00, "t2_gap");
    e(t0 + 11, 0, 1, 2'b11, "t2_tick11");
    e(t0 + 12, 0, 1, 2'b01, "t2_no12");
    e(t0 + 14, 0, 1, 2'b10, "t2_tick14");
    wr(t0 + 4, 1, 3);
    at(t0 + 15);
    // halt with div=0, then div=1
    do_reset(t0);
    for (int k = 6; k <= 27; k++) e(t0 + k, 0, 0, 2'b01, "t3_halt");
    e(t0 + 28, 0, 0, 2'b10, "t3_div1_a");
    e(t0 + 29, 0, 0, 2'b11, "t3_div1_b");
    e(t0 + 30, 0, 0, 2'b10, "t3_div1_c");
    e(t0 + 31, 0, 0, 2'b11, "t3_div1_d");
    e(t0 + 28, 0, 1, 2'b11, "t3_ch1");
    wr(t0 + 5, 0, 0);
    wr(t0 + 26, 0, 1);
    at(t0 + 32);
    // en[0] low for three edges while cnt=2
    do_reset(t0);
    for (int k = 6; k <= 10; k++) e(t0 + k, 0, 0, 2'b01, "t4_gap");
    e(t0 + 11, 0, 0, 2'b10, "t4_late");
    e(t0 + 15, 0, 0, 2'b11, "t4_next");
    e(t0 + 8, 0, 1, 2'b10, "t4_ch1");
    e(t0 + 12, 0, 1, 2'b11, "t4_ch1b");
    at(t0 + 6);
    b.en = 2'b10;
    at(t0 + 9);
    b.en = 2'b11;
    at(t0 + 16);
    // write on the terminal-count edge, and an out-of-range channel write
    do_reset(t0);
    e(t0 + 4, 0, 0, 2'b00, "t5_collide");
    e(t0 + 9, 0, 0, 2'b00, "t5_pre");
    e(t0 + 10, 0, 0, 2'b11, "t5_tick");
    e(t0 + 16, 0, 0, 2'b10, "t5_tick2");
    e(t0 + 4, 0, 1, 2'b11, "t5_ch1");
    e(t0 + 8, 0, 1, 2'b10, "t5_ch1b");
    for (int ch = 0; ch < 3; ch++) begin
      e(t0 + 7, 1, ch, 2'b01, "t5_range_pre");
      e(t0 + 8, 1, ch, 2'b10, "t5_range");
      e(t0 + 12, 1, ch, 2'b11, "t5_range2");
    end
    wr(t0 + 3, 0, 6);
    wr3(t0 + 5, 3, 2);
    at(t0 + 17);
`ifdef MULTI_CLK_DIV_SYNC_EN
    // ch1 shifted by two cycles, then sync realigns both
    do_reset(t0);
    e(t0 + 6, 0, 1, 2'b11, "t6_skew1");
    e(t0 + 8, 0, 0, 2'b10, "t6_skew0");
    e(t0 + 10, 0, 0, 2'b00, "t6_sync0");
    e(t0 + 10, 0, 1, 2'b00, "t6_sync1");
    e(t0 + 13, 0, 1, 2'b00, "t6_quiet");
    e(t0 + 14, 0, 0, 2'b11, "t6_align0");
    e(t0 + 14, 0, 1, 2'b11, "t6_align1");
    wr(t0 + 1, 1, 4);
    at(t0 + 9);
    b.sync = 1'b1;
    @(negedge clk);
    b.sync = 1'b0;
    at(t0 + 15);
`endif
    // rst mid-period restores outputs and the default divisor
    do_reset(t0);
    e(t0 + 6, 0, 1, 2'b01, "t6_pre");
    e(t0 + 7, 0, 0, 2'b00, "t6_rst0");
    e(t0 + 7, 0, 1, 2'b00, "t6_rst1");
    e(t0 + 10, 0, 0, 2'b00, "t6_div_pre");
    e(t0 + 11, 0, 0, 2'b11, "t6_div4");
    e(t0 + 11, 0, 1, 2'b11, "t6_div4_ch1");
    wr(t0 + 1, 0, 7);
    at(t0 + 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    at(t0 + 12);
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
      total++;
      bad++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
